// File: rtl/tusca_sequenciador_medida.sv
`default_nettype none
// ============================================================================
// Module      : tusca_sequenciador_medida
// Description : Periodic DHT11 measurement sequencer. Requests a measurement,
//               waits for pronto/erro under a timeout, retries a bounded
//               number of times and holds the last valid sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tusca_sequenciador_medida #(
    parameter int PERIODO_DELAY  = 100_000_000,
    parameter int TIMEOUT        = 50_000_000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        parar,
    input  logic        pronto_medida,
    input  logic        erro_medida,
    input  logic [15:0] temperatura_in,
    input  logic [15:0] umidade_in,
    output logic        medir_dht11,
    output logic [15:0] temperatura,
    output logic [15:0] umidade,
    output logic        nova_medida,
    output logic        medida_valida,
    output logic        falha,
    output logic [3:0]  db_tentativas,
    output logic [2:0]  db_estado
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DLY_W = (PERIODO_DELAY > 1) ? $clog2(PERIODO_DELAY) : 1;
    localparam logic [TMO_W-1:0] TMO_FIM  = TMO_W'(TIMEOUT - 1);
    localparam logic [DLY_W-1:0] DLY_FIM  = DLY_W'(PERIODO_DELAY - 1);
    localparam logic [3:0]       TENT_MAX = 4'(MAX_TENTATIVAS);

    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        MEDIR    = 3'd1,
        AGUARDA  = 3'd2,
        REGISTRA = 3'd3,
        RETENTA  = 3'd4,
        DELAY    = 3'd5
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [3:0]       tent_q, tent_d;
    logic [15:0]      temp_q, temp_d;
    logic [15:0]      umid_q, umid_d;
    logic             valida_q, valida_d;
    logic             falha_q, falha_d;

    // State register, counters and held sample; reset clears everything
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= INICIAL;
            tmo_cnt_q <= '0;
            dly_cnt_q <= '0;
            tent_q    <= '0;
            temp_q    <= '0;
            umid_q    <= '0;
            valida_q  <= 1'b0;
            falha_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            tmo_cnt_q <= tmo_cnt_d;
            dly_cnt_q <= dly_cnt_d;
            tent_q    <= tent_d;
            temp_q    <= temp_d;
            umid_q    <= umid_d;
            valida_q  <= valida_d;
            falha_q   <= falha_d;
        end
    end

    // Next-state logic; parar overrides every in-flight event but keeps the sample
    always_comb begin
        estado_d  = estado_q;
        tmo_cnt_d = tmo_cnt_q;
        dly_cnt_d = dly_cnt_q;
        tent_d    = tent_q;
        temp_d    = temp_q;
        umid_d    = umid_q;
        valida_d  = valida_q;
        falha_d   = falha_q;

        if (parar && (estado_q != INICIAL)) begin
            estado_d  = INICIAL;
            tmo_cnt_d = '0;
            dly_cnt_d = '0;
            tent_d    = '0;
        end else begin
            case (estado_q)
                INICIAL: begin
                    if (start && !parar) begin
                        estado_d = MEDIR;
                    end
                end
                MEDIR: begin
                    tmo_cnt_d = '0;
                    estado_d  = AGUARDA;
                end
                AGUARDA: begin
                    // erro dominates pronto; pronto dominates the timeout
                    if (erro_medida) begin
                        tmo_cnt_d = '0;
                        estado_d  = RETENTA;
                    end else if (pronto_medida) begin
                        temp_d    = temperatura_in;
                        umid_d    = umidade_in;
                        tmo_cnt_d = '0;
                        estado_d  = REGISTRA;
                    end else if (tmo_cnt_q == TMO_FIM) begin
                        tmo_cnt_d = '0;
                        estado_d  = RETENTA;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                REGISTRA: begin
                    valida_d  = 1'b1;
                    falha_d   = 1'b0;
                    tent_d    = '0;
                    dly_cnt_d = '0;
                    estado_d  = DELAY;
                end
                RETENTA: begin
                    if ((tent_q + 4'd1) == TENT_MAX) begin
                        falha_d   = 1'b1;
                        valida_d  = 1'b0;
                        tent_d    = '0;
                        dly_cnt_d = '0;
                        estado_d  = DELAY;
                    end else begin
                        tent_d   = tent_q + 4'd1;
                        estado_d = MEDIR;
                    end
                end
                DELAY: begin
                    if (dly_cnt_q == DLY_FIM) begin
                        dly_cnt_d = '0;
                        estado_d  = MEDIR;
                    end else begin
                        dly_cnt_d = dly_cnt_q + 1'b1;
                    end
                end
                default: begin
                    estado_d = INICIAL;
                end
            endcase
        end
    end

    // Outputs decoded from the current state and the held registers
    always_comb begin
        medir_dht11   = (estado_q == MEDIR);
        nova_medida   = (estado_q == REGISTRA);
        temperatura   = temp_q;
        umidade       = umid_q;
        medida_valida = valida_q;
        falha         = falha_q;
        db_tentativas = tent_q;
        db_estado     = estado_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_tusca_sequenciador_medida.sv
`default_nettype none
// ============================================================================
// Module      : tb_tusca_sequenciador_medida
// Description : Self-checking bench for the measurement sequencer: a
//               procedural timeline model plus directed literal expectations
//               and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tusca_sequenciador_medida;

    localparam int P_DELAY   = 20;
    localparam int P_TIMEOUT = 10;
    localparam int P_MAX     = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        parar = 1'b0;
    logic        pronto_medida = 1'b0;
    logic        erro_medida = 1'b0;
    logic [15:0] temperatura_in = '0;
    logic [15:0] umidade_in = '0;
    logic        medir_dht11;
    logic [15:0] temperatura;
    logic [15:0] umidade;
    logic        nova_medida;
    logic        medida_valida;
    logic        falha;
    logic [3:0]  db_tentativas;
    logic [2:0]  db_estado;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    tusca_sequenciador_medida #(
        .PERIODO_DELAY (P_DELAY),
        .TIMEOUT       (P_TIMEOUT),
        .MAX_TENTATIVAS(P_MAX)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .parar         (parar),
        .pronto_medida (pronto_medida),
        .erro_medida   (erro_medida),
        .temperatura_in(temperatura_in),
        .umidade_in    (umidade_in),
        .medir_dht11   (medir_dht11),
        .temperatura   (temperatura),
        .umidade       (umidade),
        .nova_medida   (nova_medida),
        .medida_valida (medida_valida),
        .falha         (falha),
        .db_tentativas (db_tentativas),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Expected outputs, produced by a procedural timeline of the sequence
    // ------------------------------------------------------------------
    bit        m_medir  = 1'b0;
    bit        m_nova   = 1'b0;
    bit        m_valida = 1'b0;
    bit        m_falha  = 1'b0;
    bit [15:0] m_temp   = '0;
    bit [15:0] m_umid   = '0;
    int        m_tent   = 0;
    int        m_estado = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_exp(input int estado, input bit medir, input bit nova);
        m_estado = estado;
        m_medir  = medir;
        m_nova   = nova;
    endtask

    // Advance one clock; report whether reset or parar aborted the sequence
    task automatic clk_edge(output bit stop);
        @(posedge clock);
        stop = 1'b0;
        if (reset) begin
            m_temp   = '0;
            m_umid   = '0;
            m_valida = 1'b0;
            m_falha  = 1'b0;
            stop     = 1'b1;
        end else if (parar) begin
            stop = 1'b1;
        end
        if (stop) m_tent = 0;
    endtask

    task automatic run_model();
        bit stop;
        bit got;
        bit done;
        forever begin
            // request cycle
            set_exp(1, 1'b1, 1'b0);
            clk_edge(stop);
            if (stop) return;
            // bounded wait for a response
            got  = 1'b0;
            done = 1'b0;
            for (int k = 0; k < P_TIMEOUT && !done; k++) begin
                set_exp(2, 1'b0, 1'b0);
                clk_edge(stop);
                if (stop) return;
                if (erro_medida) begin
                    done = 1'b1;
                end else if (pronto_medida) begin
                    m_temp = temperatura_in;
                    m_umid = umidade_in;
                    got    = 1'b1;
                    done   = 1'b1;
                end
            end
            if (got) begin
                set_exp(3, 1'b0, 1'b1);
                clk_edge(stop);
                if (stop) return;
                m_valida = 1'b1;
                m_falha  = 1'b0;
                m_tent   = 0;
            end else begin
                set_exp(4, 1'b0, 1'b0);
                clk_edge(stop);
                if (stop) return;
                m_tent++;
                if (m_tent == P_MAX) begin
                    m_falha  = 1'b1;
                    m_valida = 1'b0;
                    m_tent   = 0;
                end else begin
                    continue;
                end
            end
            // inter-measurement pause
            for (int k = 0; k < P_DELAY; k++) begin
                set_exp(5, 1'b0, 1'b0);
                clk_edge(stop);
                if (stop) return;
            end
        end
    endtask

    // Idle until a start is accepted, then follow the measurement timeline
    initial begin : model
        bit stop;
        forever begin
            set_exp(0, 1'b0, 1'b0);
            clk_edge(stop);
            if (!reset && start && !parar) run_model();
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            check("medir_dht11",   int'(medir_dht11),   int'(m_medir));
            check("nova_medida",   int'(nova_medida),   int'(m_nova));
            check("medida_valida", int'(medida_valida), int'(m_valida));
            check("falha",         int'(falha),         int'(m_falha));
            check("temperatura",   int'(temperatura),   int'(m_temp));
            check("umidade",       int'(umidade),       int'(m_umid));
            check("db_tentativas", int'(db_tentativas), m_tent);
            check("db_estado",     int'(db_estado),     m_estado);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_medir(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cyc();
            if (medir_dht11) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_medir: no request within %0d cycles, required one", budget);
        end
    endtask

    initial begin : stim
        int n;
        int pp;
        int pe;

        repeat (3) cyc();
        reset  = 1'b0;
        chk_en = 1'b1;
        cyc();
        check("rst_estado", int'(db_estado), 0);
        check("rst_temp",   int'(temperatura), 0);
        check("rst_valida", int'(medida_valida), 0);
        check("rst_medir",  int'(medir_dht11), 0);

        // first measurement: pronto three cycles after the request
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("first_medir", int'(medir_dht11), 1);
        cyc();
        cyc();
        cyc();
        pronto_medida  = 1'b1;
        temperatura_in = 16'h001A;
        umidade_in     = 16'h0037;
        cyc();
        pronto_medida = 1'b0;
        check("reg_nova", int'(nova_medida), 1);
        check("reg_temp", int'(temperatura), 16'h001A);
        check("reg_umid", int'(umidade), 16'h0037);
        cyc();
        check("dly_valida", int'(medida_valida), 1);
        check("dly_estado", int'(db_estado), 5);
        wait_medir(40, n);
        check("delay_spacing", n + 1, 21);

        // no response: three requests 12 cycles apart, then falha
        wait_medir(40, n);
        check("retry_spacing1", n, 12);
        wait_medir(40, n);
        check("retry_spacing2", n, 12);
        repeat (11) cyc();
        check("retenta_estado", int'(db_estado), 4);
        check("retenta_tent", int'(db_tentativas), 2);
        cyc();
        check("falha_set", int'(falha), 1);
        check("falha_valida", int'(medida_valida), 0);
        check("falha_temp", int'(temperatura), 16'h001A);
        wait_medir(40, n);
        check("falha_delay", n, P_DELAY);

        // erro on attempt 1, pronto on attempt 2
        cyc();
        cyc();
        erro_medida = 1'b1;
        cyc();
        erro_medida = 1'b0;
        check("erro_retenta", int'(db_estado), 4);
        cyc();
        check("erro_tent1", int'(db_tentativas), 1);
        check("erro_falha_sticky", int'(falha), 1);
        cyc();
        pronto_medida  = 1'b1;
        temperatura_in = 16'h0025;
        umidade_in     = 16'h0040;
        cyc();
        pronto_medida = 1'b0;
        check("retry_temp", int'(temperatura), 16'h0025);
        cyc();
        check("retry_tent0", int'(db_tentativas), 0);
        check("retry_falha0", int'(falha), 0);

        // pronto together with erro counts as erro
        wait_medir(40, n);
        cyc();
        pronto_medida  = 1'b1;
        erro_medida    = 1'b1;
        temperatura_in = 16'hBEEF;
        umidade_in     = 16'hBEEF;
        cyc();
        pronto_medida = 1'b0;
        erro_medida   = 1'b0;
        check("both_retenta", int'(db_estado), 4);
        check("both_nocapture", int'(temperatura), 16'h0025);
        cyc();

        // pronto on the last waiting cycle still captures
        repeat (10) cyc();
        pronto_medida  = 1'b1;
        temperatura_in = 16'h0031;
        umidade_in     = 16'h0042;
        cyc();
        pronto_medida = 1'b0;
        check("edge_registra", int'(db_estado), 3);
        check("edge_temp", int'(temperatura), 16'h0031);

        // parar while waiting, then a late pronto
        wait_medir(40, n);
        cyc();
        parar = 1'b1;
        cyc();
        parar = 1'b0;
        check("parar_estado", int'(db_estado), 0);
        pronto_medida  = 1'b1;
        temperatura_in = 16'h7777;
        cyc();
        pronto_medida = 1'b0;
        check("late_pronto_estado", int'(db_estado), 0);
        check("late_pronto_temp", int'(temperatura), 16'h0031);
        check("parar_valida_hold", int'(medida_valida), 1);
        start = 1'b1;
        parar = 1'b1;
        cyc();
        start = 1'b0;
        parar = 1'b0;
        check("start_parar_idle", int'(db_estado), 0);

        // reset in the middle of the pause
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        pronto_medida  = 1'b1;
        temperatura_in = 16'h0055;
        cyc();
        pronto_medida = 1'b0;
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_estado", int'(db_estado), 0);
        check("mid_rst_temp", int'(temperatura), 0);
        check("mid_rst_valida", int'(medida_valida), 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("restart_medir", int'(medir_dht11), 1);

        // randomized traffic with different response profiles
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0:       begin pp = 8;  pe = 16;   end
                1:       begin pp = 60; pe = 1000; end
                2:       begin pp = 3;  pe = 4;    end
                default: begin pp = 12; pe = 30;   end
            endcase
            for (int i = 0; i < 1500; i++) begin
                pronto_medida  = ($urandom % pp) == 0;
                erro_medida    = ($urandom % pe) == 0;
                temperatura_in = 16'($urandom);
                umidade_in     = 16'($urandom);
                start          = ($urandom % 15) == 0;
                parar          = ($urandom % 250) == 0;
                reset          = ($urandom % 900) == 0;
                cyc();
            end
        end
        pronto_medida = 1'b0;
        erro_medida   = 1'b0;
        start         = 1'b0;
        parar         = 1'b0;
        reset         = 1'b0;
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
